// File: rtl/mem_access_if.sv
// Execute / data-bus / writeback signal bundle for the memory stage.
// slave is the mem_access side, master the surrounding pipeline and bus.
interface mem_access_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_aluOut;
  logic [63:0] ex_storeData;
  logic [1:0]  ex_memOp;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [4:0]  ex_rd;
  logic        ex_regWrite;
  logic        dreq_valid;
  logic        dreq_ready;
  logic [63:0] dreq_addr;
  logic [63:0] dreq_data;
  logic [7:0]  dreq_strobe;
  logic        dreq_write;
  logic        dresp_valid;
  logic [63:0] dresp_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regWrite;
  logic        wb_fault;

  modport slave (
    input  ex_valid, ex_aluOut, ex_storeData, ex_memOp,
    input  ex_size, ex_unsigned, ex_rd, ex_regWrite,
    output ex_ready,
    output dreq_valid, dreq_addr, dreq_data, dreq_strobe, dreq_write,
    input  dreq_ready,
    input  dresp_valid, dresp_data,
    output wb_valid, wb_data, wb_rd, wb_regWrite, wb_fault,
    input  wb_ready
  );

  modport master (
    output ex_valid, ex_aluOut, ex_storeData, ex_memOp,
    output ex_size, ex_unsigned, ex_rd, ex_regWrite,
    input  ex_ready,
    input  dreq_valid, dreq_addr, dreq_data, dreq_strobe, dreq_write,
    output dreq_ready,
    output dresp_valid, dresp_data,
    input  wb_valid, wb_data, wb_rd, wb_regWrite, wb_fault,
    output wb_ready
  );
endinterface

// File: rtl/mem_access.sv
// Memory stage: one load/store in flight, bus timeout, aligned
// lane steering and sign/zero extension toward writeback.
module mem_access #(
  parameter int unsigned TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      stateNext;
  logic [7:0]  cnt;
  logic [63:0] addrQ;
  logic [63:0] dataQ;
  logic [7:0]  strobeQ;
  logic        writeQ;
  logic        unsQ;
  logic [1:0]  sizeQ;
  logic [4:0]  rdQ;
  logic        regWriteQ;
  logic [63:0] wbData;
  logic        wbRegWrite;
  logic        wbFault;

  logic        take;
  logic        misalign;
  logic        bad;
  logic        respHit;
  logic        expired;
  logic [7:0]  strobeBase;
  logic [63:0] respShift;
  logic [63:0] loadData;

  assign take    = (state == IDLE) && bus.ex_valid;
  assign respHit = (state == WAIT) && bus.dresp_valid;
  assign expired = (state == WAIT) && !bus.dresp_valid
                   && (cnt == CntLast);

  always_comb begin
    misalign   = 1'b0;
    strobeBase = 8'h01;
    unique case (bus.ex_size)
      2'd0: begin
        misalign   = 1'b0;
        strobeBase = 8'h01;
      end
      2'd1: begin
        misalign   = bus.ex_aluOut[0];
        strobeBase = 8'h03;
      end
      2'd2: begin
        misalign   = |bus.ex_aluOut[1:0];
        strobeBase = 8'h0F;
      end
      2'd3: begin
        misalign   = |bus.ex_aluOut[2:0];
        strobeBase = 8'hFF;
      end
    endcase
  end

  assign bad = (bus.ex_memOp == 2'd3)
               || ((bus.ex_memOp != 2'd0) && misalign);

  assign respShift = bus.dresp_data >> {addrQ[2:0], 3'b000};

  always_comb begin
    loadData = respShift;
    unique case (sizeQ)
      2'd0: loadData = unsQ ? {56'd0, respShift[7:0]}
                            : {{56{respShift[7]}}, respShift[7:0]};
      2'd1: loadData = unsQ ? {48'd0, respShift[15:0]}
                            : {{48{respShift[15]}}, respShift[15:0]};
      2'd2: loadData = unsQ ? {32'd0, respShift[31:0]}
                            : {{32{respShift[31]}}, respShift[31:0]};
      2'd3: loadData = respShift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (bus.ex_valid)
              stateNext = (bus.ex_memOp == 2'd0 || bad) ? DONE : REQ;
      REQ:  if (bus.dreq_ready) stateNext = WAIT;
      WAIT: if (bus.dresp_valid || cnt == CntLast) stateNext = DONE;
      DONE: if (bus.wb_ready) stateNext = IDLE;
    endcase
  end

  // Zero outside WAIT so every entry starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= 8'd0;
    else if (state != WAIT)    cnt <= 8'd0;
    else if (!bus.dresp_valid) cnt <= cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrQ      <= '0;
      dataQ      <= '0;
      strobeQ    <= '0;
      writeQ     <= 1'b0;
      unsQ       <= 1'b0;
      sizeQ      <= '0;
      rdQ        <= '0;
      regWriteQ  <= 1'b0;
      wbData     <= '0;
      wbRegWrite <= 1'b0;
      wbFault    <= 1'b0;
    end else if (take) begin
      addrQ     <= bus.ex_aluOut;
      dataQ     <= bus.ex_storeData << {bus.ex_aluOut[2:0], 3'b000};
      strobeQ   <= strobeBase << bus.ex_aluOut[2:0];
      writeQ    <= (bus.ex_memOp == 2'd2);
      unsQ      <= bus.ex_unsigned;
      sizeQ     <= bus.ex_size;
      rdQ       <= bus.ex_rd;
      regWriteQ <= bus.ex_regWrite;
      if (bus.ex_memOp == 2'd0) begin
        wbData     <= bus.ex_aluOut;
        wbRegWrite <= bus.ex_regWrite;
        wbFault    <= 1'b0;
      end else begin
        wbData     <= '0;
        wbRegWrite <= 1'b0;
        wbFault    <= bad;
      end
    end else if (respHit) begin
      wbData     <= writeQ ? 64'd0 : loadData;
      wbRegWrite <= !writeQ && regWriteQ;
      wbFault    <= 1'b0;
    end else if (expired) begin
      wbData     <= '0;
      wbRegWrite <= 1'b0;
      wbFault    <= 1'b1;
    end
  end

  assign bus.ex_ready    = (state == IDLE);
  assign bus.dreq_valid  = (state == REQ);
  assign bus.dreq_addr   = addrQ;
  assign bus.dreq_data   = dataQ;
  assign bus.dreq_strobe = strobeQ;
  assign bus.dreq_write  = writeQ;
  assign bus.wb_valid    = (state == DONE);
  assign bus.wb_data     = wbData;
  assign bus.wb_rd       = rdQ;
  assign bus.wb_regWrite = wbRegWrite;
  assign bus.wb_fault    = wbFault;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a short bus timeout.
// Inputs driven and outputs sampled on the falling edge.
module tb_mem_access;

  logic clk;
  logic rst_n;
  int   nCmp;
  int   nBad;
  int   held;
  int   w;
  int   seen;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] sd, input logic [1:0] sz,
                       input logic u, input logic [4:0] rd);
    bus.ex_memOp     = op;
    bus.ex_aluOut    = a;
    bus.ex_storeData = sd;
    bus.ex_size      = sz;
    bus.ex_unsigned  = u;
    bus.ex_rd        = rd;
    bus.ex_regWrite  = 1'b1;
    bus.ex_valid     = 1'b1;
    @(negedge clk);
    bus.ex_valid     = 1'b0;
  endtask

  task automatic toWait();
    for (int i = 0; i < 8; i++) begin
      if (!bus.dreq_valid) break;
      @(negedge clk);
    end
    chk("reqAccept", bus.dreq_valid, 0);
  endtask

  task automatic respond(input logic [63:0] d);
    bus.dresp_valid = 1'b1;
    bus.dresp_data  = d;
    @(negedge clk);
    bus.dresp_valid = 1'b0;
  endtask

  task automatic retire();
    @(negedge clk);
    chk("backIdle", bus.ex_ready, 1);
  endtask

  initial begin
    nCmp = 0;
    nBad = 0;
    rst_n = 1'b0;
    bus.ex_valid = 0;
    bus.ex_aluOut = 0;
    bus.ex_storeData = 0;
    bus.ex_memOp = 0;
    bus.ex_size = 0;
    bus.ex_unsigned = 0;
    bus.ex_rd = 0;
    bus.ex_regWrite = 0;
    bus.dreq_ready = 1'b1;
    bus.dresp_valid = 0;
    bus.dresp_data = 0;
    bus.wb_ready = 1'b1;

    #2;
    chk("rstExReady", bus.ex_ready, 1);
    chk("rstDreqValid", bus.dreq_valid, 0);
    chk("rstWbValid", bus.wb_valid, 0);
    chk("rstWbData", bus.wb_data, 0);
    chk("rstStrobe", bus.dreq_strobe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'd0, 64'h1234, 64'd0, 2'd3, 1'b0, 5'd5);
    chk("aluWbValid", bus.wb_valid, 1);
    chk("aluWbData", bus.wb_data, 64'h1234);
    chk("aluWbRd", bus.wb_rd, 5);
    chk("aluRegWr", bus.wb_regWrite, 1);
    chk("aluFault", bus.wb_fault, 0);
    retire();

    issue(2'd1, 64'h1003, 64'd0, 2'd0, 1'b0, 5'd7);
    chk("lbReqValid", bus.dreq_valid, 1);
    chk("lbStrobe", bus.dreq_strobe, 8'h08);
    chk("lbAddr", bus.dreq_addr, 64'h1003);
    chk("lbWrite", bus.dreq_write, 0);
    toWait();
    respond(64'h00000000_80000000);
    chk("lbData", bus.wb_data, 64'hFFFFFFFF_FFFFFF80);
    chk("lbRegWr", bus.wb_regWrite, 1);
    chk("lbRd", bus.wb_rd, 7);
    retire();

    issue(2'd1, 64'h1003, 64'd0, 2'd0, 1'b1, 5'd7);
    toWait();
    respond(64'h00000000_80000000);
    chk("lbuData", bus.wb_data, 64'h80);
    retire();

    bus.dreq_ready = 1'b0;
    issue(2'd2, 64'h2006, 64'hBEEF, 2'd1, 1'b0, 5'd9);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.dreq_valid) break;
      held++;
      if (i == 0 || i == 3) begin
        chk("shStrobe", bus.dreq_strobe, 8'hC0);
        chk("shData", bus.dreq_data, 64'hBEEF0000_00000000);
        chk("shWrite", bus.dreq_write, 1);
      end
      bus.dreq_ready = (i >= 3);
      @(negedge clk);
    end
    bus.dreq_ready = 1'b1;
    chk("shHeld", held, 4);
    respond(64'hDEAD);
    chk("shWbValid", bus.wb_valid, 1);
    chk("shWbData", bus.wb_data, 0);
    chk("shRegWr", bus.wb_regWrite, 0);
    chk("shFault", bus.wb_fault, 0);
    chk("shRd", bus.wb_rd, 9);
    retire();

    issue(2'd1, 64'h3002, 64'd0, 2'd2, 1'b0, 5'd11);
    chk("misReqValid", bus.dreq_valid, 0);
    chk("misWbValid", bus.wb_valid, 1);
    chk("misFault", bus.wb_fault, 1);
    chk("misRegWr", bus.wb_regWrite, 0);
    chk("misRd", bus.wb_rd, 11);
    retire();

    issue(2'd1, 64'h4000, 64'd0, 2'd3, 1'b0, 5'd12);
    toWait();
    w = 0;
    while (!bus.wb_valid && w < 20) begin
      w++;
      @(negedge clk);
    end
    chk("toWaitCyc", w, 4);
    chk("toFault", bus.wb_fault, 1);
    chk("toRegWr", bus.wb_regWrite, 0);
    chk("toRd", bus.wb_rd, 12);
    retire();
    @(negedge clk);
    respond(64'hFFFF_FFFF_FFFF_FFFF);
    chk("lateWbValid", bus.wb_valid, 0);
    chk("lateReqValid", bus.dreq_valid, 0);
    chk("lateExReady", bus.ex_ready, 1);

    issue(2'd1, 64'h4008, 64'd0, 2'd3, 1'b0, 5'd13);
    toWait();
    respond(64'h01234567_89ABCDEF);
    chk("ldData", bus.wb_data, 64'h01234567_89ABCDEF);
    chk("ldFault", bus.wb_fault, 0);
    retire();

    issue(2'd1, 64'h5004, 64'd0, 2'd2, 1'b0, 5'd14);
    toWait();
    repeat (3) @(negedge clk);
    respond(64'h87654321_00000000);
    chk("edgeFault", bus.wb_fault, 0);
    chk("edgeData", bus.wb_data, 64'hFFFFFFFF_87654321);
    retire();

    bus.dreq_ready = 1'b0;
    issue(2'd1, 64'h7000, 64'd0, 2'd3, 1'b0, 5'd15);
    chk("rqReqValid", bus.dreq_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rqAsyncReq", bus.dreq_valid, 0);
    chk("rqExReady", bus.ex_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dreq_ready = 1'b1;
    @(negedge clk);

    issue(2'd1, 64'h7008, 64'd0, 2'd3, 1'b0, 5'd16);
    toWait();
    #2 rst_n = 1'b0;
    #1;
    chk("rwReqValid", bus.dreq_valid, 0);
    chk("rwWbValid", bus.wb_valid, 0);
    chk("rwExReady", bus.ex_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    respond(64'h1111);
    seen = 0;
    repeat (3) begin
      if (bus.wb_valid) seen++;
      @(negedge clk);
    end
    chk("rwNoWb", seen, 0);

    bus.wb_ready = 1'b0;
    issue(2'd0, 64'h55, 64'd0, 2'd0, 1'b0, 5'd17);
    chk("rdWbValid", bus.wb_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rdAsyncWb", bus.wb_valid, 0);
    chk("rdWbData", bus.wb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    @(negedge clk);
    chk("rdStillIdle", bus.wb_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles spent in WAIT before a fault is declared; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low).
REQ-004 ex_valid  in  1 / ex_ready  out  1: execute-to-memory handshake; transfer when both are high at posedge.
REQ-005 ex_aluOut  in  u64: ALU result, used as byte address for loads and stores, else as writeback data.
REQ-006 ex_storeData  in  u64 / ex_memOp  in  u2 (0 none, 1 load, 2 store, 3 reserved) / ex_size  in  u2 (0 byte, 1 half, 2 word, 3 dword) / ex_unsigned  in  1.
REQ-007 ex_rd  in  u5 / ex_regWrite  in  1: destination tag, passed through to writeback.
REQ-008 dreq_valid out 1, dreq_ready in 1, dreq_addr out u64, dreq_data out u64, dreq_strobe out u8, dreq_write out 1: data-bus request channel.
REQ-009 dresp_valid in 1, dresp_data in u64: data-bus response; one response per accepted request; stores also receive a response (ack).
REQ-010 wb_valid out 1, wb_ready in 1, wb_data out u64, wb_rd out u5, wb_regWrite out 1, wb_fault out 1: writeback handshake.

Function
REQ-011 The FSM SHALL have states IDLE, REQ, WAIT, DONE; ex_ready SHALL be 1 only in IDLE.
REQ-012 IDLE, transfer with memOp 0: capture inputs, go to DONE; wb_data = ex_aluOut; wb_valid high the next cycle (latency 1).
REQ-013 IDLE, transfer with load/store, aligned: go to REQ; dreq_valid high the next cycle.
REQ-014 Alignment SHALL require addr[0]=0 for half, addr[1:0]=0 for word, addr[2:0]=0 for dword; a misaligned access or memOp 3 SHALL go straight to DONE with wb_fault=1, wb_regWrite=0, and no bus request.
REQ-015 REQ: dreq_valid=1 with stable addr/data/strobe/write until dreq_ready=1 at a posedge, then go to WAIT.
REQ-016 dreq_addr SHALL be the full ex_aluOut, and dreq_write SHALL be 1 for a store.
REQ-017 dreq_strobe SHALL be {01,03,0F,FF}[size] shifted left by addr[2:0], and dreq_data SHALL be ex_storeData shifted left by 8*addr[2:0], with bits above 64 discarded.
REQ-018 WAIT: a 8-bit counter SHALL clear on entry and increment each cycle without dresp_valid.
REQ-019 WAIT on dresp_valid: go to DONE; for a load, wb_data = (dresp_data >> 8*addr[2:0]) truncated to the size, then sign-extended, or zero-extended when ex_unsigned=1 (dword is unaffected); for a store, wb_data = 0 and wb_regWrite = 0.
REQ-020 WAIT, counter reaching TIMEOUT without a response: go to DONE with wb_fault=1 and wb_regWrite=0.
REQ-021 dresp_valid SHALL be ignored outside WAIT, which discards late responses after a timeout.
REQ-022 DONE: wb_valid=1 with all wb_* outputs stable until wb_ready=1 at a posedge, then return to IDLE; the next ex transfer is possible only in the following cycle.
REQ-023 A dresp_valid that arrives in the same cycle the counter reaches TIMEOUT SHALL win, and no fault is raised.
REQ-024 wb_rd SHALL equal the captured ex_rd on every completion, including faults.

Reset
REQ-025 While rst_n=0: state IDLE, counter 0, and every output 0 except ex_ready=1; dreq_valid and wb_valid SHALL fall asynchronously, without waiting for a clock.
REQ-026 Reset asserted mid-transaction SHALL abandon it, with no writeback produced; a bus response arriving after reset SHALL be ignored.

Verification
REQ-027 ALU pass-through: memOp 0, aluOut 0x1234, rd 5, wb_ready=1 -> wb_valid exactly 1 cycle after transfer, wb_data 0x1234, wb_rd 5.
REQ-028 Signed byte load: addr 0x1003, dresp_data 0x00000000_80000000 -> dreq_strobe 0x08, wb_data 0xFFFFFFFF_FFFFFF80; with ex_unsigned=1 -> 0x80.
REQ-029 Half store: addr 0x2006, storeData 0xBEEF, dreq_ready low 3 cycles -> dreq_valid held 4 cycles, strobe 0xC0, dreq_data 0xBEEF0000_00000000, wb_regWrite 0.
REQ-030 Misaligned word load at 0x3002 -> no dreq_valid, wb_fault 1 one cycle after transfer.
REQ-031 Timeout: TIMEOUT=4, no response -> wb_fault 1 after 4 WAIT cycles; a response 2 cycles later is ignored, and the next load completes normally.
REQ-032 Reset asserted in WAIT and released -> dreq_valid and wb_valid are 0 immediately, ex_ready is 1, and no writeback occurs.
